// File: rtl/store_merge_unit.sv
// Store path to a 64-bit data memory: sd writes straight through, while sb/sh/sw
// read the enclosing doubleword, merge the new bytes in and write it back.
module store_merge_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rdata,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_D    = 2'd3;
  localparam logic [2:0] LAST_WAIT = 3'(READ_LAT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  wait_cnt_reg, wait_cnt_next;
  logic [1:0]  size_reg;
  logic [2:0]  off_reg;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic [63:0] wbuf_reg;
  logic        err_reg;

  logic        misaligned;
  logic [3:0]  nbytes;
  logic [63:0] merged;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = |addr[1:0];
      2'd3:    misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign nbytes = 4'd1 << size_reg;

  // Byte gi takes wdata byte (gi - off) when it falls inside the store window.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      logic [3:0] rel;
      logic       hit;
      assign rel = 4'(gi) - {1'b0, off_reg};
      assign hit = !rel[3] && ({1'b0, rel[2:0]} < nbytes);
      assign merged[gi*8 +: 8] = hit ? wdata_reg[{rel[2:0], 3'b000} +: 8]
                                     : mem_rdata[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          wait_cnt_next = 3'd0;
          if (misaligned)
            state_next = DONE;
          else if (size == SIZE_D)
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ: begin
        if (wait_cnt_reg == LAST_WAIT)
          state_next = MERGE;
        else
          wait_cnt_next = wait_cnt_reg + 3'd1;
      end
      MERGE:   state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 3'd0;
      size_reg     <= 2'd0;
      off_reg      <= 3'd0;
      addr_reg     <= 64'd0;
      wdata_reg    <= 64'd0;
      wbuf_reg     <= 64'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            size_reg  <= size;
            off_reg   <= addr[2:0];
            addr_reg  <= {addr[63:3], 3'b000};
            wdata_reg <= wdata;
            // sd writes the request data unmodified; sub-doubleword stores overwrite this in MERGE
            wbuf_reg  <= wdata;
            err_reg   <= misaligned;
          end
        end
        MERGE: wbuf_reg <= merged;
        DONE: begin
          addr_reg <= 64'd0;
          err_reg  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wr    = (state_reg == WRITE);
  assign mem_wdata = (state_reg == WRITE) ? wbuf_reg : 64'd0;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign err       = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: one DUT with READ_LAT=1 and one with READ_LAT=3.
module tb_store_merge_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  size;
  logic [63:0] addr, wdata, mem_rdata;
  logic [63:0] a1_addr, a1_wdata, a3_addr, a3_wdata;
  logic        a1_wr, a1_busy, a1_done, a1_err;
  logic        a3_wr, a3_busy, a3_done, a3_err;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  store_merge_unit #(.READ_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .mem_addr(a1_addr), .mem_rdata(mem_rdata), .mem_wr(a1_wr), .mem_wdata(a1_wdata),
    .busy(a1_busy), .done(a1_done), .err(a1_err));

  store_merge_unit #(.READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .mem_addr(a3_addr), .mem_rdata(mem_rdata), .mem_wr(a3_wr), .mem_wdata(a3_wdata),
    .busy(a3_busy), .done(a3_done), .err(a3_err));

  // Drive a one-cycle start; returns at the negedge of cycle t+1.
  task automatic issue(input logic [1:0] s, input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    start = 1'b1; size = s; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0; size = 2'd0; addr = 64'd0; wdata = 64'd0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; size = 2'd0; addr = 64'd0; wdata = 64'd0; mem_rdata = 'x;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (a1_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", a1_busy); end
    tests_run++; if (a1_done !== 1'b0 || a1_err !== 1'b0) begin tests_failed++; $display("FAIL reset_done_err got=%b%b want=00", a1_done, a1_err); end
    tests_run++; if (a1_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_wr got=%b want=0", a1_wr); end
    tests_run++; if (a1_addr !== 64'd0 || a1_wdata !== 64'd0) begin tests_failed++; $display("FAIL reset_addr_wdata got=%h/%h want=0/0", a1_addr, a1_wdata); end
    $display("[TB] reset checked");
  endtask

  task automatic test_sd;
    mem_rdata = 'x;
    issue(2'd3, 64'h100, 64'h1122334455667788);
    tests_run++; if (a1_wr !== 1'b1) begin tests_failed++; $display("FAIL sd_wr got=%b want=1", a1_wr); end
    tests_run++; if (a1_addr !== 64'h100) begin tests_failed++; $display("FAIL sd_addr got=%h want=100", a1_addr); end
    tests_run++; if (a1_wdata !== 64'h1122334455667788) begin tests_failed++; $display("FAIL sd_wdata got=%h want=1122334455667788", a1_wdata); end
    @(negedge clk);
    tests_run++; if (a1_done !== 1'b1 || a1_err !== 1'b0 || a1_wr !== 1'b0) begin tests_failed++; $display("FAIL sd_done got done=%b err=%b wr=%b want 1 0 0", a1_done, a1_err, a1_wr); end
    @(negedge clk);
    tests_run++; if (a1_busy !== 1'b0 || a1_addr !== 64'd0) begin tests_failed++; $display("FAIL sd_idle got busy=%b addr=%h want 0 0", a1_busy, a1_addr); end
    $display("[TB] sd addr=100 wdata=1122334455667788");
    idle_cycles(4);
  endtask

  // Sub-doubleword store on the READ_LAT=1 instance: checks READ/MERGE/WRITE/DONE timing.
  task automatic test_rmw(input string name, input logic [1:0] s, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] rd,
                          input logic [63:0] exp_addr, input logic [63:0] exp_data);
    mem_rdata = rd;
    issue(s, a, d);
    tests_run++; if (a1_wr !== 1'b0 || a1_busy !== 1'b1 || a1_addr !== exp_addr) begin tests_failed++; $display("FAIL %s_read got wr=%b busy=%b addr=%h want 0 1 %h", name, a1_wr, a1_busy, a1_addr, exp_addr); end
    @(negedge clk);
    tests_run++; if (a1_wr !== 1'b0 || a1_addr !== exp_addr) begin tests_failed++; $display("FAIL %s_merge got wr=%b addr=%h want 0 %h", name, a1_wr, a1_addr, exp_addr); end
    @(negedge clk);
    mem_rdata = 'x;
    tests_run++; if (a1_wr !== 1'b1 || a1_wdata !== exp_data) begin tests_failed++; $display("FAIL %s_write got wr=%b wdata=%h want 1 %h", name, a1_wr, a1_wdata, exp_data); end
    @(negedge clk);
    tests_run++; if (a1_done !== 1'b1 || a1_err !== 1'b0 || a1_wr !== 1'b0) begin tests_failed++; $display("FAIL %s_done got done=%b err=%b wr=%b want 1 0 0", name, a1_done, a1_err, a1_wr); end
    $display("[TB] %s addr=%h wdata=%h merged=%h", name, a, d, a1_wdata);
    idle_cycles(6);
  endtask

  task automatic test_misaligned(input logic [1:0] s, input logic [63:0] a);
    int wr_seen;
    wr_seen = 0;
    issue(s, a, 64'hFFFF_FFFF_FFFF_FFFF);
    if (a1_wr) wr_seen++;
    tests_run++; if (a1_done !== 1'b1 || a1_err !== 1'b1) begin tests_failed++; $display("FAIL misaligned_done size=%0d addr=%h got done=%b err=%b want 1 1", s, a, a1_done, a1_err); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (a1_wr) wr_seen++; end
    tests_run++; if (wr_seen !== 0 || a1_busy !== 1'b0) begin tests_failed++; $display("FAIL misaligned_nowr size=%0d got wr_cycles=%0d busy=%b want 0 0", s, wr_seen, a1_busy); end
    $display("[TB] misaligned size=%0d addr=%h err", s, a);
    idle_cycles(4);
  endtask

  task automatic test_reset_mid;
    int events;
    events = 0;
    mem_rdata = 64'h0;
    issue(2'd1, 64'h100, 64'h1234);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (a1_busy !== 1'b0 || a1_wr !== 1'b0 || a1_done !== 1'b0 || a1_addr !== 64'd0) begin tests_failed++; $display("FAIL midreset_idle got busy=%b wr=%b done=%b addr=%h want all 0", a1_busy, a1_wr, a1_done, a1_addr); end
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (a1_wr || a1_done || a3_wr || a3_done) events++; end
    tests_run++; if (events !== 0) begin tests_failed++; $display("FAIL midreset_quiet got events=%0d want 0", events); end
    mem_rdata = 'x;
    issue(2'd3, 64'h8, 64'hA5A5_0000_5A5A_FFFF);
    tests_run++; if (a1_wr !== 1'b1 || a1_wdata !== 64'hA5A5_0000_5A5A_FFFF || a1_addr !== 64'h8) begin tests_failed++; $display("FAIL midreset_sd got wr=%b wdata=%h addr=%h want 1 a5a500005a5affff 8", a1_wr, a1_wdata, a1_addr); end
    @(negedge clk);
    tests_run++; if (a1_done !== 1'b1 || a1_err !== 1'b0) begin tests_failed++; $display("FAIL midreset_sd_done got done=%b err=%b want 1 0", a1_done, a1_err); end
    $display("[TB] reset during sh READ, then sd addr=8");
    idle_cycles(6);
  endtask

  task automatic test_back_to_back;
    logic exp_busy, exp_done;
    int   waited;
    mem_rdata = 64'h0123456789ABCDEF;
    @(negedge clk);
    start = 1'b1; size = 2'd1; addr = 64'h102; wdata = 64'h0000_BEEF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_busy = (k <= 6) || (k == 8);
      exp_done = (k == 6);
      tests_run++; if (a3_busy !== exp_busy || a3_done !== exp_done) begin tests_failed++; $display("FAIL b2b_cycle%0d got busy=%b done=%b want %b %b", k, a3_busy, a3_done, exp_busy, exp_done); end
      if (k == 5) begin
        tests_run++; if (a3_wr !== 1'b1 || a3_wdata !== 64'h01234567BEEFCDEF) begin tests_failed++; $display("FAIL b2b_write got wr=%b wdata=%h want 1 01234567beefcdef", a3_wr, a3_wdata); end
      end
    end
    start = 1'b0; size = 2'd0; addr = 64'd0; wdata = 64'd0;
    waited = 0;
    while ((a1_busy || a3_busy) && waited < 20) begin @(negedge clk); waited++; end
    tests_run++; if (a1_busy || a3_busy) begin tests_failed++; $display("FAIL b2b_drain got busy=%b%b want 00", a1_busy, a3_busy); end
    $display("[TB] sh addr=102 held start, READ_LAT=3");
  endtask

  initial begin
    test_reset();
    test_sd();
    test_rmw("sb", 2'd0, 64'h203, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF, 64'h200, 64'hFFFFFFFFABFFFFFF);
    test_rmw("sw", 2'd2, 64'h10C, 64'hDEADBEEF, 64'h0123456789ABCDEF, 64'h108, 64'hDEADBEEF89ABCDEF);
    test_rmw("sh", 2'd1, 64'h106, 64'h5555_CAFE, 64'h0011223344556677, 64'h100, 64'hCAFE223344556677);
    test_rmw("sb_hi", 2'd0, 64'h7F0, 64'hFFFF_FF3C, 64'h0, 64'h7F0, 64'h3C);
    test_misaligned(2'd1, 64'h101);
    test_misaligned(2'd3, 64'h104);
    test_misaligned(2'd2, 64'h102);
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
